// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between requesters, the shared logic unit and its consumer.
interface logic_unit_arbiter_if #(
  parameter int WORD_SIZE = 19,
  parameter int N_REQ     = 2,
  parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]           req_valid;
  logic [2*N_REQ-1:0]         req_op;
  logic [N_REQ*WORD_SIZE-1:0] req_a;
  logic [N_REQ*WORD_SIZE-1:0] req_b;
  logic [N_REQ-1:0]           req_ready;
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [WORD_SIZE-1:0]       rsp_data;
  logic                       rsp_ready;
  logic                       busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared AND/OR/XOR/NOT unit; result registered, 1-cycle latency.
// Accepts only when the result register is empty or draining; a stalled consumer blocks all grants.
module logic_unit_arbiter #(
  parameter int WORD_SIZE = 19,
  parameter int N_REQ     = 2,
  parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_unit_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      rsp_id_q;
  logic [WORD_SIZE-1:0] rsp_data_q;

  logic                 grant_vld;
  logic [ID_W-1:0]      grant_idx;
  logic                 can_accept;
  logic                 accept;
  logic [1:0]           op_sel;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  logic [WORD_SIZE-1:0] op_res;

  assign can_accept = (state == EMPTY) || bus.rsp_ready;
  assign accept     = can_accept && grant_vld;

  // Walk from rr_ptr upward (mod N_REQ); iterating backwards lets the closest hit win.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    op_sel = bus.req_op[2*int'(grant_idx) +: 2];
    op_a   = bus.req_a[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
    op_b   = bus.req_b[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
    case (op_sel)
      2'b00:   op_res = op_a & op_b;
      2'b01:   op_res = op_a | op_b;
      2'b10:   op_res = op_a ^ op_b;
      default: op_res = ~op_a;
    endcase
  end

  assign bus.req_ready = (accept && rst_n) ? (N_REQ'(1) << grant_idx) : '0;
  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state == FULL) || (|bus.req_valid);

  // An accept in FULL replaces the draining result in the same edge, so state stays FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rr_ptr     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else if (accept) begin
      state      <= FULL;
      rsp_id_q   <= grant_idx;
      rsp_data_q <= op_res;
      rr_ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (state == FULL && bus.rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule
